// File: rtl/digit_stream_buffer_if.sv
// Handshake/bus bundle between digit_stream_buffer and its surroundings
// (UART receiver, UART transmitter, display driver).
//
//   rx_ready, rx_data      : receiver byte-ready level and received byte
//   clear, submit          : live-buffer clear level, snapshot/transmit request level
//   scroll_tick            : one-cycle display window advance
//   tx_busy                : transmitter busy
//   tx_start, tx_data      : registered start pulse and byte to the transmitter
//   count                  : digit count of the current snapshot
//   win_digits             : WINDOW-digit view, leftmost digit in the MSBs
//   busy, done             : TX engine active, last-byte-complete pulse
//
// slave  : the buffer side (digit_stream_buffer)
// master : the environment side (receiver/transmitter/display/testbench)
interface digit_stream_buffer_if #(
  parameter int DIGIT_W = 4,
  parameter int WINDOW  = 4,
  parameter int CNT_W   = 4
);
  logic                        rx_ready;
  logic [7:0]                  rx_data;
  logic                        clear;
  logic                        submit;
  logic                        scroll_tick;
  logic                        tx_busy;
  logic                        tx_start;
  logic [7:0]                  tx_data;
  logic [CNT_W-1:0]            count;
  logic [WINDOW*DIGIT_W-1:0]   win_digits;
  logic                        busy;
  logic                        done;

  modport slave (
    input  rx_ready, rx_data, clear, submit, scroll_tick, tx_busy,
    output tx_start, tx_data, count, win_digits, busy, done
  );

  modport master (
    output rx_ready, rx_data, clear, submit, scroll_tick, tx_busy,
    input  tx_start, tx_data, count, win_digits, busy, done
  );
endinterface

// File: rtl/digit_stream_buffer.sv
// digit_stream_buffer
//   Collects decoded digits from the UART receiver into a DEPTH-entry shift
//   buffer (newest digit at index DEPTH-1). A submit rising edge freezes a
//   snapshot, which is retransmitted as ASCII ('0' + digit, oldest first)
//   through a busy/start handshake, and shown to the display driver as a
//   scrolling WINDOW-digit view.
//
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   bus    : digit_stream_buffer_if.slave (see the interface file for fields)
//
// Configuration macro:
//   DIGIT_FILTER_EN : when defined, only ASCII '0'..'9' (8'h30..8'h39) bytes
//                     are pushed; other bytes leave the live buffer untouched.
module digit_stream_buffer #(
  parameter int DEPTH   = 8,
  parameter int DIGIT_W = 4,
  parameter int WINDOW  = 4,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  digit_stream_buffer_if.slave     bus
);

  localparam int BUF_W = DEPTH * DIGIT_W;
  localparam int WIN_W = WINDOW * DIGIT_W;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] WINDOW_C = CNT_W'(WINDOW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_t;

  logic             r_rx_ready_d;
  logic             r_clear_d;
  logic             r_submit_d;
  logic             r_submit_pls;
  logic [BUF_W-1:0] r_live;
  logic [CNT_W-1:0] r_live_cnt;
  logic [BUF_W-1:0] r_snap;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_offset;
  logic [WIN_W-1:0] r_win;
  state_t           r_state;
  logic [CNT_W-1:0] r_idx;
  logic             r_tx_start;
  logic [7:0]       r_tx_data;

  logic             w_rx_rise;
  logic             w_clear_rise;
  logic             w_push;
  logic             w_load;
  logic [BUF_W-1:0] w_live_shift;
  logic [CNT_W-1:0] w_off_max;
  logic [CNT_W-1:0] w_base;
  logic [WIN_W-1:0] w_win;
  logic [CNT_W-1:0] w_tx_sel;
  logic [DIGIT_W-1:0] w_tx_digit;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_idx_nxt;
  logic             w_tx_start_nxt;
  logic [7:0]       w_tx_data_nxt;

  assign w_rx_rise    = bus.rx_ready & ~r_rx_ready_d;
  assign w_clear_rise = bus.clear & ~r_clear_d;

`ifdef DIGIT_FILTER_EN
  assign w_push = w_rx_rise && (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
`else
  assign w_push = w_rx_rise;
  // Upper byte bits carry no digit information in this build.
  logic w_unused_rx;
  assign w_unused_rx = ^bus.rx_data;
`endif

  // Submit is acted on one cycle after its edge is seen, and only from IDLE.
  assign w_load = r_submit_pls && (r_state == S_IDLE);

  // Live buffer shifted toward index 0 with the new digit entering at the top.
  always_comb begin
    w_live_shift = r_live >> DIGIT_W;
    w_live_shift[BUF_W-1 -: DIGIT_W] = bus.rx_data[DIGIT_W-1:0];
  end

  // Window base leaves leading zero positions when fewer than WINDOW digits.
  assign w_off_max = (r_count > WINDOW_C) ? (r_count - WINDOW_C) : '0;
  assign w_base    = DEPTH_C - ((r_count > WINDOW_C) ? r_count : WINDOW_C);

  always_comb begin
    w_win = '0;
    for (int j = 0; j < WINDOW; j++) begin
      w_win[(WINDOW-1-j)*DIGIT_W +: DIGIT_W] =
        r_snap[(int'(w_base) + int'(r_offset) + j)*DIGIT_W +: DIGIT_W];
    end
  end

  // Oldest snapshot digit lives at DEPTH-count; r_idx walks forward from it.
  assign w_tx_sel   = DEPTH_C - r_count + r_idx;
  assign w_tx_digit = r_snap[int'(w_tx_sel)*DIGIT_W +: DIGIT_W];

  // ---- input edge detection ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_ready_d <= 1'b0;
      r_clear_d    <= 1'b0;
      r_submit_d   <= 1'b0;
      r_submit_pls <= 1'b0;
    end else begin
      r_rx_ready_d <= bus.rx_ready;
      r_clear_d    <= bus.clear;
      r_submit_d   <= bus.submit;
      r_submit_pls <= bus.submit & ~r_submit_d;
    end
  end

  // ---- live buffer ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_live     <= '0;
      r_live_cnt <= '0;
    end else if (w_clear_rise) begin
      r_live     <= '0;
      r_live_cnt <= '0;
    end else if (w_push) begin
      r_live <= w_live_shift;
      if (r_live_cnt != DEPTH_C) begin
        r_live_cnt <= r_live_cnt + CNT_W'(1);
      end
    end
  end

  // ---- snapshot, window offset, window register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snap   <= '0;
      r_count  <= '0;
      r_offset <= '0;
      r_win    <= '0;
    end else begin
      if (w_load) begin
        r_snap   <= r_live;
        r_count  <= r_live_cnt;
        r_offset <= '0;
      end else if (bus.scroll_tick) begin
        r_offset <= (r_offset >= w_off_max) ? '0 : (r_offset + CNT_W'(1));
      end
      r_win <= w_win;
    end
  end

  // ---- TX state register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_tx_data  <= w_tx_data_nxt;
    end
  end

  // ---- TX next state ----
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_tx_start_nxt = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    case (r_state)
      S_IDLE: begin
        // An empty snapshot is still loaded but never starts a transfer.
        if (w_load && (r_live_cnt != '0)) begin
          w_state_nxt = S_SEND;
          w_idx_nxt   = '0;
        end
      end
      S_SEND: begin
        if (!bus.tx_busy) begin
          w_tx_start_nxt = 1'b1;
          w_tx_data_nxt  = 8'h30 + 8'(w_tx_digit);
          w_state_nxt    = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (bus.tx_busy) begin
          w_state_nxt = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!bus.tx_busy) begin
          if ((r_idx + CNT_W'(1)) == r_count) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx + CNT_W'(1);
            w_state_nxt = S_SEND;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.tx_start   = r_tx_start;
  assign bus.tx_data    = r_tx_data;
  assign bus.count      = r_count;
  assign bus.win_digits = r_win;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = (r_state == S_DONE);

endmodule
